tx_controller: RTL

TX_CONTROLLER -- requirements
Module: tx_controller

---
 rtl/uart_pkg.sv | 25 ++
 rtl/tx_fifo.sv | 71 +++++++
 rtl/tx_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int         DATA_BITS    = 8;
  localparam logic       START_BIT    = 1'b0;
  localparam logic       STOP_BIT     = 1'b1;
  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

  // Width of a counter that holds 0..cpb-1 (never narrower than one bit).
  function automatic int baud_width(input int cpb);
    if (cpb > 1) begin
      return $clog2(cpb);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO for the UART transmitter. Pushes into a full FIFO and pops from
// an empty FIFO are ignored; a push and a pop in the same cycle both apply.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_rdata,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_push;
  logic                 w_pop;

  // Full is judged on the current occupancy, so a write while full is lost
  // even when a pop frees a slot on the same edge.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == CNT_W'(0));
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy counter, unchanged on a simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CNT_W'(0);
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tx_controller.sv
// UART 8N1 transmitter: byte FIFO feeding a serializer with a baud counter.
// Frames are sent back to back while the FIFO has data.
module tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TX_WE,
  input  logic [7:0] TX_DATA,
  output logic       TX_FULL,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       UART_TXD
);

  localparam int                BAUD_W    = baud_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [BAUD_W-1:0]    r_baud;
  logic [BAUD_W-1:0]    w_baud_nxt;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_txd;
  logic                 w_txd_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_rdata;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (TX_WE),
    .i_wdata (TX_DATA),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: each bit lasts until the baud counter hits its last count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == LAST_BIT_IDX)) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_bit_end && !w_fifo_empty) begin
          w_state_nxt = ST_START;
        end else if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath decode: pop, counters, shift load and next line level.
  always_comb begin
    w_pop         = 1'b0;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_txd_nxt     = STOP_BIT;
    w_done_nxt    = 1'b0;

    // A new byte is taken either from idle or straight at the end of a stop bit.
    if ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end)) begin
      w_pop = !w_fifo_empty;
    end else begin
      w_pop = 1'b0;
    end

    if ((r_state == ST_IDLE) || w_bit_end) begin
      w_baud_nxt = BAUD_W'(0);
    end else begin
      w_baud_nxt = r_baud + BAUD_W'(1);
    end

    if (r_state != ST_DATA) begin
      w_bit_idx_nxt = 3'd0;
    end else if (w_bit_end) begin
      w_bit_idx_nxt = r_bit_idx + 3'd1;
    end else begin
      w_bit_idx_nxt = r_bit_idx;
    end

    if (w_pop) begin
      w_shift_nxt = w_fifo_rdata;
    end else begin
      w_shift_nxt = r_shift;
    end

    case (w_state_nxt)
      ST_IDLE:  w_txd_nxt = STOP_BIT;
      ST_START: w_txd_nxt = START_BIT;
      ST_DATA:  w_txd_nxt = w_shift_nxt[w_bit_idx_nxt];
      ST_STOP:  w_txd_nxt = STOP_BIT;
      default:  w_txd_nxt = STOP_BIT;
    endcase

    // Look ahead one cycle so the registered pulse lands on the last stop cycle.
    w_done_nxt = (w_state_nxt == ST_STOP) && (w_baud_nxt == BAUD_LAST);
  end

  // Datapath registers: baud counter, bit index and the frame's byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= BAUD_W'(0);
      r_bit_idx <= 3'd0;
      r_shift   <= '0;
    end else begin
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Registered serial line and done pulse; reset drives the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd  <= STOP_BIT;
      r_done <= 1'b0;
    end else begin
      r_txd  <= w_txd_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign UART_TXD = r_txd;
  assign TX_DONE  = r_done;
  assign TX_FULL  = w_fifo_full;
  assign TX_BUSY  = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
